beat_line_deserializer: RTL and testbench

//  Receiving end of the beat timing interface: consumes the blackout

---
 rtl/beat_line_deserializer.sv | 148 ++++++++++++++
 tb/tb_beat_line_deserializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/beat_line_deserializer.sv
// beat_line_deserializer
// Receiving end of the beat timing interface. Captures one serial store bit
// per digit pulse during each unblanked line, reassembles a LINE_LENGTH-bit
// word and publishes it, tagged action/scan, through a one-entry valid/ready
// buffer. Short lines, long lines and overruns raise one-cycle pulses.
module beat_line_deserializer #(
    parameter int LINE_LENGTH = 32
) (
    input  logic                             w_CLK,
    input  logic                             w_RST_N,
    input  logic                             w_BO_WF,
    input  logic                             w_HA_WF,
    input  logic                             w_DP,
    input  logic                             w_SERIAL,
    output logic [LINE_LENGTH-1:0]           w_WORD,
    output logic                             w_WORD_ACTION,
    output logic                             w_WORD_VALID,
    input  logic                             w_WORD_READY,
    output logic [$clog2(LINE_LENGTH+1)-1:0] w_DIGIT,
    output logic                             w_ERR_SHORT,
    output logic                             w_ERR_LONG,
    output logic                             w_OVERRUN
);

    localparam int CW = $clog2(LINE_LENGTH + 1);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        COLLECT = 2'd1,
        FLYBACK = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   bo_q;
    logic [LINE_LENGTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]          count_q, count_d;
    logic [LINE_LENGTH-1:0] word_q, word_d;
    logic                   action_q, action_d;
    logic                   valid_q, valid_d;
    logic                   err_short_q, err_short_d;
    logic                   err_long_q, err_long_d;
    logic                   overrun_q, overrun_d;

    logic fall, rise, accept, publish, line_full;

    assign fall      = bo_q & ~w_BO_WF;
    assign rise      = ~bo_q & w_BO_WF;
    assign accept    = valid_q & w_WORD_READY;
    assign line_full = (count_q == CW'(LINE_LENGTH));

    // Line FSM, digit capture and output-buffer next-state logic
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        count_d     = count_q;
        word_d      = word_q;
        action_d    = action_q;
        valid_d     = valid_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        overrun_d   = 1'b0;
        publish     = 1'b0;

        case (state_q)
            SYNC: begin
                if (fall) begin
                    state_d = COLLECT;
                    count_d = '0;
                    shreg_d = '0;
                end
            end
            COLLECT: begin
                // A strobe coincident with rise sees w_BO_WF=1 and is dropped
                if (w_DP && !w_BO_WF) begin
                    if (!line_full) begin
                        for (int unsigned i = 0; i < LINE_LENGTH; i++) begin
                            if (count_q == CW'(i)) shreg_d[i] = w_SERIAL;
                        end
                        count_d = count_q + CW'(1);
                    end else begin
                        err_long_d = 1'b1;
                    end
                end
                if (rise) begin
                    state_d = FLYBACK;
                    if (line_full) publish = 1'b1;
                    else           err_short_d = 1'b1;
                end
            end
            FLYBACK: begin
                if (fall) begin
                    state_d = COLLECT;
                    count_d = '0;
                    shreg_d = '0;
                end
            end
            default: state_d = SYNC;
        endcase

        // Acceptance frees the slot in the same cycle a new word may load
        if (accept) valid_d = 1'b0;
        if (publish) begin
            if (!valid_q || accept) begin
                word_d   = shreg_q;
                action_d = w_HA_WF;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State and output registers, cleared by asynchronous reset
    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N) begin
            state_q     <= SYNC;
            bo_q        <= 1'b0;
            shreg_q     <= '0;
            count_q     <= '0;
            word_q      <= '0;
            action_q    <= 1'b0;
            valid_q     <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bo_q        <= w_BO_WF;
            shreg_q     <= shreg_d;
            count_q     <= count_d;
            word_q      <= word_d;
            action_q    <= action_d;
            valid_q     <= valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            overrun_q   <= overrun_d;
        end
    end

    assign w_WORD        = word_q;
    assign w_WORD_ACTION = action_q;
    assign w_WORD_VALID  = valid_q;
    assign w_DIGIT       = count_q;
    assign w_ERR_SHORT   = err_short_q;
    assign w_ERR_LONG    = err_long_q;
    assign w_OVERRUN     = overrun_q;

endmodule

// File: tb/tb_beat_line_deserializer.sv
// tb_beat_line_deserializer
// Directed bench for beat_line_deserializer with hand-computed expectations.
module tb_beat_line_deserializer;

    localparam int LL = 32;

    logic          w_CLK = 1'b0;
    logic          w_RST_N;
    logic          w_BO_WF;
    logic          w_HA_WF;
    logic          w_DP;
    logic          w_SERIAL;
    logic [LL-1:0] w_WORD;
    logic          w_WORD_ACTION;
    logic          w_WORD_VALID;
    logic          w_WORD_READY;
    logic [5:0]    w_DIGIT;
    logic          w_ERR_SHORT;
    logic          w_ERR_LONG;
    logic          w_OVERRUN;

    int n_checks = 0;
    int n_pass   = 0;

    beat_line_deserializer #(.LINE_LENGTH(LL)) dut (
        .w_CLK         (w_CLK),
        .w_RST_N       (w_RST_N),
        .w_BO_WF       (w_BO_WF),
        .w_HA_WF       (w_HA_WF),
        .w_DP          (w_DP),
        .w_SERIAL      (w_SERIAL),
        .w_WORD        (w_WORD),
        .w_WORD_ACTION (w_WORD_ACTION),
        .w_WORD_VALID  (w_WORD_VALID),
        .w_WORD_READY  (w_WORD_READY),
        .w_DIGIT       (w_DIGIT),
        .w_ERR_SHORT   (w_ERR_SHORT),
        .w_ERR_LONG    (w_ERR_LONG),
        .w_OVERRUN     (w_OVERRUN)
    );

    always #5 w_CLK = ~w_CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Apply inputs for one cycle; returns 1 time unit after the active edge
    task automatic drive(input logic bo, input logic dp, input logic ser);
        w_BO_WF  = bo;
        w_DP     = dp;
        w_SERIAL = ser;
        @(posedge w_CLK);
        #1;
    endtask

    task automatic digits(input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, data[i]);
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Fall, 32 digits, then the rise cycle with the given halver level
    task automatic full_line(input logic [31:0] data, input logic ha);
        drive(1'b0, 1'b0, 1'b0);
        digits(data, 32);
        w_HA_WF = ha;
        drive(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        w_RST_N = 1'b0; w_BO_WF = 1'b1; w_HA_WF = 1'b0; w_DP = 1'b0;
        w_SERIAL = 1'b0; w_WORD_READY = 1'b0;
        repeat (2) @(posedge w_CLK);
        #1;
        chk("rst_valid", 32'(w_WORD_VALID), 32'd0);
        chk("rst_word", w_WORD, 32'h0);
        chk("rst_digit", 32'(w_DIGIT), 32'd0);
        chk("rst_errs", {29'd0, w_ERR_SHORT, w_ERR_LONG, w_OVERRUN}, 32'd0);
        w_RST_N = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);

        // 1: full line, action beat
        drive(1'b0, 1'b0, 1'b0);
        digits(32'hA5A5_0F0F, 32);
        chk("t1_digit", 32'(w_DIGIT), 32'd32);
        chk("t1_valid_pre", 32'(w_WORD_VALID), 32'd0);
        w_HA_WF = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        chk("t1_valid", 32'(w_WORD_VALID), 32'd1);
        chk("t1_word", w_WORD, 32'hA5A5_0F0F);
        chk("t1_action", 32'(w_WORD_ACTION), 32'd1);
        chk("t1_short", 32'(w_ERR_SHORT), 32'd0);
        w_WORD_READY = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        w_WORD_READY = 1'b0;
        chk("t1_drained", 32'(w_WORD_VALID), 32'd0);
        chk("t1_word_held", w_WORD, 32'hA5A5_0F0F);

        // 2: short line
        drive(1'b0, 1'b0, 1'b0);
        digits(32'hFFFF_FFFF, 31);
        chk("t2_digit", 32'(w_DIGIT), 32'd31);
        drive(1'b1, 1'b0, 1'b0);
        chk("t2_short", 32'(w_ERR_SHORT), 32'd1);
        chk("t2_valid", 32'(w_WORD_VALID), 32'd0);
        drive(1'b1, 1'b0, 1'b0);
        chk("t2_short_end", 32'(w_ERR_SHORT), 32'd0);
        chk("t2_valid2", 32'(w_WORD_VALID), 32'd0);

        // 3: long line
        drive(1'b0, 1'b0, 1'b0);
        digits(32'h1234_5678, 32);
        chk("t3_long_pre", 32'(w_ERR_LONG), 32'd0);
        drive(1'b0, 1'b1, 1'b1);
        chk("t3_long", 32'(w_ERR_LONG), 32'd1);
        chk("t3_digit_sat", 32'(w_DIGIT), 32'd32);
        drive(1'b0, 1'b0, 1'b0);
        chk("t3_long_end", 32'(w_ERR_LONG), 32'd0);
        w_HA_WF = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        chk("t3_valid", 32'(w_WORD_VALID), 32'd1);
        chk("t3_word", w_WORD, 32'h1234_5678);
        chk("t3_action", 32'(w_WORD_ACTION), 32'd0);
        w_WORD_READY = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        w_WORD_READY = 1'b0;
        chk("t3_drained", 32'(w_WORD_VALID), 32'd0);

        // 4: overrun, then accept-and-load in the same cycle
        full_line(32'h1, 1'b1);
        chk("t4_word1", w_WORD, 32'h1);
        chk("t4_valid1", 32'(w_WORD_VALID), 32'd1);
        full_line(32'h2, 1'b1);
        chk("t4_overrun", 32'(w_OVERRUN), 32'd1);
        chk("t4_word_kept", w_WORD, 32'h1);
        chk("t4_valid_kept", 32'(w_WORD_VALID), 32'd1);
        drive(1'b1, 1'b0, 1'b0);
        chk("t4_overrun_end", 32'(w_OVERRUN), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        digits(32'h2, 32);
        w_WORD_READY = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        w_WORD_READY = 1'b0;
        chk("t4_word2", w_WORD, 32'h2);
        chk("t4_valid2", 32'(w_WORD_VALID), 32'd1);
        chk("t4_no_overrun", 32'(w_OVERRUN), 32'd0);
        w_WORD_READY = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        w_WORD_READY = 1'b0;
        chk("t4_drained", 32'(w_WORD_VALID), 32'd0);

        // 5: strobes coincident with fall and rise are ignored
        drive(1'b0, 1'b1, 1'b1);
        chk("t5_fall_dp", 32'(w_DIGIT), 32'd0);
        digits(32'hDEAD_BEEF, 32);
        w_HA_WF = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        chk("t5_rise_dp", 32'(w_DIGIT), 32'd32);
        chk("t5_long", 32'(w_ERR_LONG), 32'd0);
        chk("t5_word", w_WORD, 32'hDEAD_BEEF);
        chk("t5_valid", 32'(w_WORD_VALID), 32'd1);

        // 6: reset mid-line with a full buffer, released with BO low
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        digits(32'h0, 22);
        w_RST_N = 1'b0;
        #2;
        chk("t6_rst_valid", 32'(w_WORD_VALID), 32'd0);
        chk("t6_rst_word", w_WORD, 32'h0);
        chk("t6_rst_digit", 32'(w_DIGIT), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        w_RST_N = 1'b1;
        digits(32'h3FF, 10);
        chk("t6_no_capture", 32'(w_DIGIT), 32'd0);
        drive(1'b1, 1'b0, 1'b0);
        chk("t6_no_short", 32'(w_ERR_SHORT), 32'd0);
        chk("t6_no_valid", 32'(w_WORD_VALID), 32'd0);
        full_line(32'hCAFE_F00D, 1'b0);
        chk("t6_word", w_WORD, 32'hCAFE_F00D);
        chk("t6_valid", 32'(w_WORD_VALID), 32'd1);
        chk("t6_action", 32'(w_WORD_ACTION), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
